// File: rtl/washer_pkg.sv
// rtl/washer_pkg.sv - phase codes and phase durations for the washer sequencer
package washer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        FILL  = 3'b001,
        WASH  = 3'b010,
        RINSE = 3'b011,
        SPIN  = 3'b100
    } state_t;

    localparam int unsigned FILL_MIN  = 2;
    localparam int unsigned WASH_MIN  = 5;
    localparam int unsigned RINSE_MIN = 2;
    localparam int unsigned SPIN_MIN  = 1;

    // IDLE maps to 1 so limit-1 never underflows; the timer is disabled there anyway.
    function automatic int unsigned phase_minutes(state_t s);
        case (s)
            FILL:    phase_minutes = FILL_MIN;
            WASH:    phase_minutes = WASH_MIN;
            RINSE:   phase_minutes = RINSE_MIN;
            SPIN:    phase_minutes = SPIN_MIN;
            default: phase_minutes = 1;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase cycle counter that flags the last cycle of a phase
module phase_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // A load always wins so every phase starts from zero, even if it is entered paused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == (limit - 1'b1)) && enable;

endmodule

// File: rtl/washer_cycle_ctrl.sv
// rtl/washer_cycle_ctrl.sv - coin-started fill/wash/rinse/spin sequencer with spin-lid pause
module washer_cycle_ctrl
    import washer_pkg::*;
#(
    parameter int unsigned TICKS_PER_MIN = 4,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_in,
    input  logic       double_wash,
    input  logic       timer_pause,
    output logic [2:0] state,
    output logic       busy,
    output logic       paused,
    output logic       wash_done
);

    state_t           cur_state;
    state_t           next_state;
    logic             dw_reg;
    logic             pass;
    logic             load;
    logic             enable;
    logic             done;
    logic             second_pass;
    logic [CNT_W-1:0] limit;

    assign paused      = (cur_state == SPIN) && timer_pause;
    assign enable      = (cur_state != IDLE) && !paused;
    assign load        = (next_state != cur_state);
    assign limit       = CNT_W'(phase_minutes(cur_state)) * CNT_W'(TICKS_PER_MIN);
    assign second_pass = dw_reg && !pass;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .enable (enable),
        .limit  (limit),
        .done   (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:    if (coin_in) next_state = FILL;
            FILL:    if (done)    next_state = WASH;
            WASH:    if (done)    next_state = RINSE;
            RINSE:   if (done)    next_state = second_pass ? WASH : SPIN;
            SPIN:    if (done)    next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    // double_wash only matters at acceptance; pass marks that the repeat WASH is underway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dw_reg    <= 1'b0;
            pass      <= 1'b0;
            wash_done <= 1'b0;
        end else begin
            wash_done <= (cur_state == SPIN) && done;
            if (cur_state == IDLE) begin
                pass <= 1'b0;
                if (coin_in) begin
                    dw_reg <= double_wash;
                end
            end else if ((cur_state == RINSE) && done && second_pass) begin
                pass <= 1'b1;
            end
        end
    end

    assign state = cur_state;
    assign busy  = (cur_state != IDLE);

endmodule

// File: tb/tb_washer_cycle_ctrl.sv
// tb/tb_washer_cycle_ctrl.sv - directed and random checks of washer_cycle_ctrl against a phase-list model
module tb_washer_cycle_ctrl;

    localparam int T       = 4;
    localparam int P_IDLE  = 0;
    localparam int P_FILL  = 1;
    localparam int P_WASH  = 2;
    localparam int P_RINSE = 3;
    localparam int P_SPIN  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_in = 1'b0;
    logic       double_wash = 1'b0;
    logic       timer_pause = 1'b0;
    logic [2:0] state;
    logic       busy;
    logic       paused;
    logic       wash_done;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int paused_cnt = 0;

    int m_cur = P_IDLE;
    int m_elapsed = 0;
    bit m_done = 1'b0;
    int m_plan[$];

    washer_cycle_ctrl #(
        .TICKS_PER_MIN (T),
        .CNT_W         (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_in     (coin_in),
        .double_wash (double_wash),
        .timer_pause (timer_pause),
        .state       (state),
        .busy        (busy),
        .paused      (paused),
        .wash_done   (wash_done)
    );

    always #5 clk = ~clk;

    function automatic int phase_len(int p);
        case (p)
            P_FILL:  return 2 * T;
            P_WASH:  return 5 * T;
            P_RINSE: return 2 * T;
            P_SPIN:  return 1 * T;
            default: return 0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, int exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Machine as a list of phases still to run; advances once per clock edge.
    task automatic model_update();
        if (rst) begin
            m_cur = P_IDLE;
            m_elapsed = 0;
            m_done = 1'b0;
            m_plan.delete();
        end else begin
            m_done = 1'b0;
            if (m_cur == P_IDLE) begin
                if (coin_in) begin
                    if (double_wash) m_plan = '{P_FILL, P_WASH, P_RINSE, P_WASH, P_RINSE, P_SPIN};
                    else             m_plan = '{P_FILL, P_WASH, P_RINSE, P_SPIN};
                    m_cur = m_plan.pop_front();
                    m_elapsed = 0;
                end
            end else if (!(m_cur == P_SPIN && timer_pause)) begin
                m_elapsed++;
                if (m_elapsed == phase_len(m_cur)) begin
                    m_elapsed = 0;
                    if (m_plan.size() == 0) begin
                        m_cur = P_IDLE;
                        m_done = 1'b1;
                    end else begin
                        m_cur = m_plan.pop_front();
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("state", 32'(state), m_cur);
        chk("busy", 32'(busy), int'(m_cur != P_IDLE));
        chk("paused", 32'(paused), int'((m_cur == P_SPIN) && timer_pause));
        chk("wash_done", 32'(wash_done), int'(m_done));
        if (busy === 1'b1)      busy_cnt++;
        if (wash_done === 1'b1) done_cnt++;
        if (paused === 1'b1)    paused_cnt++;
    endtask

    task automatic clear_counts();
        busy_cnt = 0;
        done_cnt = 0;
        paused_cnt = 0;
    endtask

    initial begin
        timer_pause = 1'b1;
        #12;
        chk("reset_state", 32'(state), P_IDLE);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_paused", 32'(paused), 0);
        chk("reset_wash_done", 32'(wash_done), 0);
        step();
        rst = 1'b0;
        timer_pause = 1'b0;

        // single wash
        clear_counts();
        for (int i = 0; i < 50; i++) begin
            coin_in = (i == 0);
            step();
            if (i == 40) begin
                chk("single_idle_at_41", 32'(state), P_IDLE);
                chk("single_done_at_41", 32'(wash_done), 1);
            end
        end
        chk("single_busy_cycles", 32'(busy_cnt), 40);
        chk("single_done_count", 32'(done_cnt), 1);

        // double wash, selection dropped after acceptance
        clear_counts();
        for (int i = 0; i < 80; i++) begin
            coin_in = (i == 0);
            double_wash = (i == 0);
            step();
        end
        chk("double_busy_cycles", 32'(busy_cnt), 68);
        chk("double_done_count", 32'(done_cnt), 1);

        // pause in WASH (no effect) and 3 cycles at SPIN count 2
        clear_counts();
        for (int i = 0; i < 55; i++) begin
            coin_in = (i == 0);
            timer_pause = (i >= 12 && i <= 16) || (i >= 39 && i <= 41);
            step();
        end
        timer_pause = 1'b0;
        chk("pause_busy_cycles", 32'(busy_cnt), 43);
        chk("pause_paused_cycles", 32'(paused_cnt), 3);
        chk("pause_done_count", 32'(done_cnt), 1);

        // pause held at the last SPIN count
        clear_counts();
        for (int i = 0; i < 60; i++) begin
            coin_in = (i == 0);
            timer_pause = (i >= 40 && i <= 49);
            step();
            if (i == 49) chk("hold_last_spin", 32'(state), P_SPIN);
            if (i == 50) chk("hold_release_idle", 32'(state), P_IDLE);
        end
        timer_pause = 1'b0;
        chk("hold_busy_cycles", 32'(busy_cnt), 50);
        chk("hold_paused_cycles", 32'(paused_cnt), 10);

        // stray coins ignored; held coin restarts in the wash_done cycle
        clear_counts();
        for (int i = 0; i < 42; i++) begin
            coin_in = (i == 0) || (i == 15) || (i == 30) || (i >= 35);
            step();
            if (i == 40) chk("b2b_done_cycle", 32'(wash_done), 1);
            if (i == 41) chk("b2b_refill", 32'(state), P_FILL);
        end
        coin_in = 1'b0;
        for (int i = 0; i < 45; i++) step();
        chk("b2b_done_count", 32'(done_cnt), 2);
        chk("b2b_busy_cycles", 32'(busy_cnt), 80);

        // asynchronous reset mid-WASH
        for (int i = 0; i < 20; i++) begin
            coin_in = (i == 0);
            step();
        end
        coin_in = 1'b0;
        chk("pre_reset_wash", 32'(state), P_WASH);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_state", 32'(state), P_IDLE);
        chk("async_reset_busy", 32'(busy), 0);
        model_update();
        step();
        step();
        rst = 1'b0;
        clear_counts();
        for (int i = 0; i < 6; i++) step();
        chk("post_reset_no_done", 32'(done_cnt), 0);
        chk("post_reset_idle", 32'(busy_cnt), 0);
        for (int i = 0; i < 45; i++) begin
            coin_in = (i == 0);
            step();
        end
        chk("post_reset_busy_cycles", 32'(busy_cnt), 40);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            coin_in     = ($urandom_range(7) == 0);
            double_wash = $urandom_range(1) == 1;
            timer_pause = ($urandom_range(3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
